// File: rtl/audio_codec_i2c_cfg.sv
// SSM2603 power-up configuration sequencer: walks an 11-entry register table and
// writes each entry over I2C through an internal open-drain bit-level master.
module audio_codec_i2c_cfg #(
  parameter int         CLK_HZ     = 50000000,
  parameter int         I2C_HZ     = 100000,
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         PWR_DELAY  = 1000000,
  parameter int         MAX_RETRY  = 3,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       start,
  output logic       i2c_scl_o,
  output logic       i2c_sda_oe,
  input  logic       i2c_sda_i,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] reg_idx
);

  localparam int QDIV   = CLK_HZ / (4 * I2C_HZ);
  localparam int DIV_W  = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int WAIT_W = (PWR_DELAY > 1) ? $clog2(PWR_DELAY) : 1;
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [3:0] LAST_IDX = 4'd10;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PWR_WAIT = 4'd1;
  localparam logic [3:0] S_START    = 4'd2;
  localparam logic [3:0] S_SHIFT    = 4'd3;
  localparam logic [3:0] S_ACK      = 4'd4;
  localparam logic [3:0] S_STOP     = 4'd5;
  localparam logic [3:0] S_GAP      = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_FAIL     = 4'd8;

  // Table entries are {reg[6:0], data[8:0]}, in the codec's recommended power-up order.
  function automatic logic [15:0] tbl_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    tbl_entry = {7'd15, 9'h000};
      4'd1:    tbl_entry = {7'd6,  9'h070};
      4'd2:    tbl_entry = {7'd0,  9'h017};
      4'd3:    tbl_entry = {7'd1,  9'h017};
      4'd4:    tbl_entry = {7'd2,  9'h079};
      4'd5:    tbl_entry = {7'd3,  9'h079};
      4'd6:    tbl_entry = {7'd4,  9'h012};
      4'd7:    tbl_entry = {7'd5,  9'h000};
      4'd8:    tbl_entry = {7'd7,  9'h04A};
      4'd9:    tbl_entry = {7'd8,  9'h000};
      4'd10:   tbl_entry = {7'd9,  9'h001};
      default: tbl_entry = 16'h0000;
    endcase
  endfunction

  logic [3:0]        r_state;
  logic [DIV_W-1:0]  r_div;
  logic [1:0]        r_q;
  logic [2:0]        r_bit;
  logic [1:0]        r_byte;
  logic [RTY_W-1:0]  r_retry;
  logic [WAIT_W-1:0] r_wait;
  logic              r_fail;
  logic              r_nack;
  logic              r_auto;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [3:0]        r_idx;
  logic              r_scl;
  logic              r_sda_oe;

  logic              w_tick;
  logic              w_qend;
  logic              w_in_frame;
  logic [15:0]       w_entry;
  logic [7:0]        w_byte;
  logic              w_bit;
  logic              w_scl;
  logic              w_sda_oe;

  assign w_tick     = (r_div == DIV_W'(QDIV - 1));
  assign w_qend     = w_tick && (r_q == 2'd3);
  assign w_in_frame = (r_state == S_START) || (r_state == S_SHIFT) || (r_state == S_ACK) ||
                      (r_state == S_STOP)  || (r_state == S_GAP);
  assign w_entry    = tbl_entry(r_idx);
  assign w_bit      = w_byte[3'd7 - r_bit];

  always_comb begin
    w_byte = {DEV_ADDR, 1'b0};
    case (r_byte)
      2'd1:    w_byte = w_entry[15:8];
      2'd2:    w_byte = w_entry[7:0];
      default: w_byte = {DEV_ADDR, 1'b0};
    endcase
  end

  // Pin levels per quarter; registered below so the pins never see decode glitches.
  always_comb begin
    w_scl    = 1'b1;
    w_sda_oe = 1'b0;
    case (r_state)
      S_START: begin
        w_scl    = (r_q != 2'd3);
        w_sda_oe = (r_q != 2'd0);
      end
      S_SHIFT: begin
        w_scl    = r_q[1];
        w_sda_oe = ~w_bit;
      end
      S_ACK:   w_scl = r_q[1];
      S_STOP: begin
        w_scl    = r_q[1];
        w_sda_oe = (r_q != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_q      <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_retry  <= '0;
      r_wait   <= '0;
      r_fail   <= 1'b0;
      r_nack   <= 1'b0;
      r_auto   <= AUTO_START;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_idx    <= '0;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
    end else begin
      r_scl    <= w_scl;
      r_sda_oe <= w_sda_oe;
      if (w_in_frame) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) r_q <= r_q + 1'b1;
      end
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (r_auto) begin
            r_auto  <= 1'b0;
            r_wait  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_PWR_WAIT;
          end else if (start) begin
            r_idx   <= '0;
            r_retry <= '0;
            r_fail  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_PWR_WAIT: begin
          if (r_wait == WAIT_W'(PWR_DELAY - 1)) r_state <= S_START;
          else                                 r_wait  <= r_wait + 1'b1;
        end
        S_START: if (w_qend) r_state <= S_SHIFT;
        S_SHIFT: begin
          if (w_qend) begin
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (w_tick && (r_q == 2'd2)) r_nack <= i2c_sda_i;
          if (w_qend) begin
            if (r_nack || (r_byte == 2'd2)) begin
              r_fail  <= r_nack;
              r_byte  <= '0;
              r_state <= S_STOP;
            end else begin
              r_byte  <= r_byte + 1'b1;
              r_state <= S_SHIFT;
            end
          end
        end
        S_STOP: if (w_qend) r_state <= S_GAP;
        S_GAP: begin
          if (w_qend) begin
            r_fail <= 1'b0;
            if (!r_fail) begin
              if (r_idx == LAST_IDX) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_retry <= '0;
                r_state <= S_START;
              end
            end else if (r_retry < RTY_W'(MAX_RETRY)) begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_START;
            end else begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FAIL;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i2c_scl_o  = r_scl;
  assign i2c_sda_oe = r_sda_oe;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign reg_idx    = r_idx;

endmodule
